// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU slice.
// Holds the symbolic opcodes, the matching ALU control words {zx,nx,zy,ny,f,no},
// and the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ZERO = 4'd0;
  localparam logic [3:0] OP_ONE  = 4'd1;
  localparam logic [3:0] OP_NEG1 = 4'd2;
  localparam logic [3:0] OP_A    = 4'd3;
  localparam logic [3:0] OP_B    = 4'd4;
  localparam logic [3:0] OP_NOTA = 4'd5;
  localparam logic [3:0] OP_NEGA = 4'd6;
  localparam logic [3:0] OP_INCA = 4'd7;
  localparam logic [3:0] OP_DECA = 4'd8;
  localparam logic [3:0] OP_ADD  = 4'd9;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_RSUB = 4'd11;
  localparam logic [3:0] OP_AND  = 4'd12;
  localparam logic [3:0] OP_OR   = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_RSVD = 4'd15;

  localparam logic [5:0] CW_ZERO = 6'b101010;
  localparam logic [5:0] CW_ONE  = 6'b111111;
  localparam logic [5:0] CW_NEG1 = 6'b111010;
  localparam logic [5:0] CW_A    = 6'b001100;
  localparam logic [5:0] CW_B    = 6'b110000;
  localparam logic [5:0] CW_NOTA = 6'b001101;
  localparam logic [5:0] CW_NEGA = 6'b001111;
  localparam logic [5:0] CW_INCA = 6'b011111;
  localparam logic [5:0] CW_DECA = 6'b001110;
  localparam logic [5:0] CW_ADD  = 6'b000010;
  localparam logic [5:0] CW_SUB  = 6'b010011;
  localparam logic [5:0] CW_RSUB = 6'b000111;
  localparam logic [5:0] CW_AND  = 6'b000000;
  localparam logic [5:0] CW_OR   = 6'b010101;

  typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_e;

endpackage

// File: rtl/alu.sv
// Existing 4-bit combinational ALU.
// Ports: x, y operands; zx/nx/zy/ny zero/negate each input; f selects add (1) or and (0);
// no negates the result; out result, zr result==0, ng result MSB.
module alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_out;

  always_comb begin
    w_x = zx ? '0 : x;
    if (nx) w_x = ~w_x;
    w_y = zy ? '0 : y;
    if (ny) w_y = ~w_y;
    w_f   = f ? (w_x + w_y) : (w_x & w_y);
    w_out = no ? ~w_f : w_f;
  end

  assign out = w_out;
  assign zr  = (w_out == '0);
  assign ng  = w_out[WIDTH-1];

endmodule

// File: rtl/alu_op_decode.sv
// Opcode decoder: symbolic 4-bit opcode -> ALU control word {zx,nx,zy,ny,f,no}.
// Ports: i_op opcode; o_ctrl control word; o_err opcode is reserved for this build.
// MUL is sequenced by the caller, so its control word here is a don't-care.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic [3:0] i_op,
  output logic [5:0] o_ctrl,
  output logic       o_err
);

  always_comb begin
    o_ctrl = CW_ZERO;
    o_err  = 1'b0;
    unique case (i_op)
      OP_ZERO: o_ctrl = CW_ZERO;
      OP_ONE:  o_ctrl = CW_ONE;
      OP_NEG1: o_ctrl = CW_NEG1;
      OP_A:    o_ctrl = CW_A;
      OP_B:    o_ctrl = CW_B;
      OP_NOTA: o_ctrl = CW_NOTA;
      OP_NEGA: o_ctrl = CW_NEGA;
      OP_INCA: o_ctrl = CW_INCA;
      OP_DECA: o_ctrl = CW_DECA;
      OP_ADD:  o_ctrl = CW_ADD;
      OP_SUB:  o_ctrl = CW_SUB;
      OP_RSUB: o_ctrl = CW_RSUB;
      OP_AND:  o_ctrl = CW_AND;
      OP_OR:   o_ctrl = CW_OR;
      OP_MUL:  o_err  = !MUL_EN;
      OP_RSVD: o_err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_seq.sv
// Round-robin front end sharing one combinational ALU between two requesters.
// Ports: clk/rst_n; req0_*/req1_* valid/ready request ports (op, a, b);
// rsp_* registered valid/ready response port (id, data, zr, ng, err).
// MUL is done by repeated addition through the same ALU, one add per cycle.
module alu_arbiter_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zr,
  output logic             rsp_ng,
  output logic             rsp_err
);

  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  state_e           r_state;
  logic             r_last_grant;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_cnt;

  logic             w_gnt0;
  logic             w_gnt1;
  logic [3:0]       w_sel_op;
  logic [5:0]       w_dec_ctrl;
  logic             w_dec_err;
  logic [WIDTH-1:0] w_alu_x;
  logic [WIDTH-1:0] w_alu_y;
  logic [5:0]       w_alu_ctrl;
  logic [WIDTH-1:0] w_alu_out;
  logic             w_alu_zr;
  logic             w_alu_ng;

  // Contention goes to whoever did not win last time.
  assign w_gnt0   = req0_valid && (!req1_valid || r_last_grant);
  assign w_gnt1   = req1_valid && (!req0_valid || !r_last_grant);
  assign w_sel_op = w_gnt1 ? req1_op : req0_op;

  assign req0_ready = (r_state == StIdle) && w_gnt0;
  assign req1_ready = (r_state == StIdle) && w_gnt1;

  alu_op_decode #(
    .MUL_EN (MUL_EN)
  ) u_decode (
    .i_op   (r_op),
    .o_ctrl (w_dec_ctrl),
    .o_err  (w_dec_err)
  );

  // MUL steers acc+a while counting down, then passes acc through as a plain A op.
  always_comb begin
    w_alu_x    = r_a;
    w_alu_y    = r_b;
    w_alu_ctrl = w_dec_ctrl;
    if (r_state == StMul) begin
      w_alu_x    = r_acc;
      w_alu_y    = r_a;
      w_alu_ctrl = (r_cnt != '0) ? CW_ADD : CW_A;
    end
  end

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .x   (w_alu_x),
    .y   (w_alu_y),
    .zx  (w_alu_ctrl[5]),
    .nx  (w_alu_ctrl[4]),
    .zy  (w_alu_ctrl[3]),
    .ny  (w_alu_ctrl[2]),
    .f   (w_alu_ctrl[1]),
    .no  (w_alu_ctrl[0]),
    .out (w_alu_out),
    .zr  (w_alu_zr),
    .ng  (w_alu_ng)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_zr       <= 1'b0;
      rsp_ng       <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_gnt0 || w_gnt1) begin
            r_op         <= w_sel_op;
            r_a          <= w_gnt1 ? req1_a : req0_a;
            r_b          <= w_gnt1 ? req1_b : req0_b;
            rsp_id       <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_acc        <= '0;
            r_cnt        <= w_gnt1 ? req1_b : req0_b;
            r_state      <= ((w_sel_op == OP_MUL) && MUL_EN) ? StMul : StExec;
          end
        end
        StExec: begin
          if (w_dec_err) begin
            rsp_data <= '0;
            rsp_zr   <= 1'b1;
            rsp_ng   <= 1'b0;
          end else begin
            rsp_data <= w_alu_out;
            rsp_zr   <= w_alu_zr;
            rsp_ng   <= w_alu_ng;
          end
          rsp_err   <= w_dec_err;
          rsp_valid <= 1'b1;
          r_state   <= StResp;
        end
        StMul: begin
          if (r_cnt != '0) begin
            r_acc <= w_alu_out;
            r_cnt <= r_cnt - CntOne;
          end else begin
            rsp_data  <= w_alu_out;
            rsp_zr    <= w_alu_zr;
            rsp_ng    <= w_alu_ng;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            r_state   <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
